// File: rtl/song_sequencer_pkg.sv
// Shared note codes, widths, FSM state and ROM entry layout for the autoplay sequencer.
package song_sequencer_pkg;

    localparam int NOTE_W = 4;
    localparam int LED_W  = 8;
    localparam int STEP_W = 5;
    localparam int DUR_W  = 3;

    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D    = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP, ST_DONE} state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } rom_entry_t;

    // Codes above C5 play as silence for their full duration.
    function automatic logic [NOTE_W-1:0] note_clip(input logic [NOTE_W-1:0] n);
        return (n > NOTE_C5) ? NOTE_NONE : n;
    endfunction

    function automatic logic [LED_W-1:0] note_led(input logic [NOTE_W-1:0] n);
        logic [LED_W-1:0] l;
        l = '0;
        if (n != NOTE_NONE && n <= NOTE_C5)
            l = 8'h01 << (4'd8 - n);
        return l;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control inputs and note/LED outputs of the autoplay sequencer.
interface song_sequencer_if;
    import song_sequencer_pkg::*;

    logic              ENABLE;
    logic              BEAT_TICK;
    logic [NOTE_W-1:0] note;
    logic [LED_W-1:0]  Led;
    logic [STEP_W-1:0] step;
    logic              song_done;

    modport master (output ENABLE, BEAT_TICK, input note, Led, step, song_done);
    modport slave  (input ENABLE, BEAT_TICK, output note, Led, step, song_done);
endinterface

// File: rtl/song_sequencer_rom.sv
// Combinational song ROM, addr -> {note, dur}. ROM_SEL=0 is the Ode to Joy phrase;
// ROM_SEL=1 is a short pattern exercising dur=0 and an out-of-range note code.
module song_rom
    import song_sequencer_pkg::*;
#(
    parameter int ROM_SEL = 0
) (
    input  logic [STEP_W-1:0] addr,
    output rom_entry_t        dat
);

    always_comb begin
        dat = '{note: NOTE_NONE, dur: 3'd1};
        if (ROM_SEL == 0) begin
            case (addr)
                5'd0:  dat = '{note: NOTE_E,  dur: 3'd2};
                5'd1:  dat = '{note: NOTE_E,  dur: 3'd2};
                5'd2:  dat = '{note: NOTE_F,  dur: 3'd2};
                5'd3:  dat = '{note: NOTE_G,  dur: 3'd2};
                5'd4:  dat = '{note: NOTE_G,  dur: 3'd2};
                5'd5:  dat = '{note: NOTE_F,  dur: 3'd2};
                5'd6:  dat = '{note: NOTE_E,  dur: 3'd2};
                5'd7:  dat = '{note: NOTE_D,  dur: 3'd2};
                5'd8:  dat = '{note: NOTE_C4, dur: 3'd2};
                5'd9:  dat = '{note: NOTE_C4, dur: 3'd2};
                5'd10: dat = '{note: NOTE_D,  dur: 3'd2};
                5'd11: dat = '{note: NOTE_E,  dur: 3'd2};
                5'd12: dat = '{note: NOTE_E,  dur: 3'd3};
                5'd13: dat = '{note: NOTE_D,  dur: 3'd1};
                5'd14: dat = '{note: NOTE_D,  dur: 3'd4};
                default: dat = '{note: NOTE_NONE, dur: 3'd1};
            endcase
        end else begin
            case (addr)
                5'd0:  dat = '{note: NOTE_C4, dur: 3'd1};
                5'd1:  dat = '{note: NOTE_C4, dur: 3'd0};
                5'd2:  dat = '{note: NOTE_D,  dur: 3'd2};
                5'd3:  dat = '{note: 4'd9,    dur: 3'd1};
                5'd4:  dat = '{note: NOTE_C5, dur: 3'd1};
                default: dat = '{note: NOTE_NONE, dur: 3'd1};
            endcase
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Autoplay sequencer: steps through song_rom on BEAT_TICK, inserting a NONE gap between
// notes; note/Led/step/song_done are registered, ENABLE=0 rewinds to IDLE next cycle.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int SONG_LEN   = 15,
    parameter int GAP_CYCLES = 2,
    parameter bit LOOP       = 1'b0,
    parameter int ROM_SEL    = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    song_sequencer_if.slave  bus
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0]     GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SONG_LEN - 1);

    state_t            state;
    logic [STEP_W-1:0] step_q;
    logic [DUR_W-1:0]  tick_cnt;
    logic [DUR_W-1:0]  cur_dur;
    logic [GW-1:0]     gap_cnt;
    logic [NOTE_W-1:0] note_q;
    logic [LED_W-1:0]  led_q;
    logic              done_q;

    logic [STEP_W-1:0] rom_addr;
    rom_entry_t        rom_dat;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;
    logic              at_last;
    logic              tick_end;
    logic              advance;

    // The ROM is only ever read for the note about to be loaded; its dur is latched.
    song_rom #(.ROM_SEL(ROM_SEL)) u_rom (
        .addr (rom_addr),
        .dat  (rom_dat)
    );

    always_comb begin
        at_last  = (step_q == LAST_STEP);
        rom_addr = (state == ST_IDLE || at_last) ? '0 : step_q + 5'd1;
        rom_note = note_clip(rom_dat.note);
        rom_dur  = (rom_dat.dur == '0) ? 3'd1 : rom_dat.dur;
        tick_end = bus.BEAT_TICK && (({1'b0, tick_cnt} + 4'd1) == {1'b0, cur_dur});
        advance  = ((state == ST_PLAY) && tick_end && (GAP_CYCLES == 0)) ||
                   ((state == ST_GAP) && (gap_cnt == GAP_LAST));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            step_q   <= '0;
            tick_cnt <= '0;
            cur_dur  <= 3'd1;
            gap_cnt  <= '0;
            note_q   <= NOTE_NONE;
            led_q    <= '0;
            done_q   <= 1'b0;
        end else if (!bus.ENABLE) begin
            state    <= ST_IDLE;
            step_q   <= '0;
            tick_cnt <= '0;
            gap_cnt  <= '0;
            note_q   <= NOTE_NONE;
            led_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (advance) begin
                tick_cnt <= '0;
                gap_cnt  <= '0;
                if (!at_last) begin
                    state   <= ST_PLAY;
                    step_q  <= step_q + 5'd1;
                    note_q  <= rom_note;
                    led_q   <= note_led(rom_note);
                    cur_dur <= rom_dur;
                end else begin
                    done_q <= 1'b1;
                    if (LOOP) begin
                        state   <= ST_PLAY;
                        step_q  <= '0;
                        note_q  <= rom_note;
                        led_q   <= note_led(rom_note);
                        cur_dur <= rom_dur;
                    end else begin
                        state  <= ST_DONE;
                        note_q <= NOTE_NONE;
                        led_q  <= '0;
                    end
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_PLAY;
                        step_q   <= '0;
                        tick_cnt <= '0;
                        note_q   <= rom_note;
                        led_q    <= note_led(rom_note);
                        cur_dur  <= rom_dur;
                    end
                    ST_PLAY: begin
                        if (tick_end) begin
                            state    <= ST_GAP;
                            gap_cnt  <= '0;
                            tick_cnt <= '0;
                            note_q   <= NOTE_NONE;
                            led_q    <= '0;
                        end else if (bus.BEAT_TICK) begin
                            tick_cnt <= tick_cnt + 3'd1;
                        end
                    end
                    ST_GAP:  gap_cnt <= gap_cnt + GW'(1);
                    ST_DONE: state   <= ST_DONE;
                    default: state   <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.note      = note_q;
    assign bus.Led       = led_q;
    assign bus.step      = step_q;
    assign bus.song_done = done_q;

endmodule
